// File: rtl/dcache_wb_if.sv
// CPU-side and memory-side signal bundle for the write-back data cache.
// The slave modport is the cache. The master modport is the core plus the
// memory controller that drive it.
interface dcache_wb_if;
   logic [31:0] addr;
   logic        rd_req;
   logic        wr_req;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        miss;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   modport master (
      output addr, rd_req, wr_req, wr_be, wr_data, mem_rdata, mem_ack,
      input  rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
   );

   modport slave (
      input  addr, rd_req, wr_req, wr_be, wr_data, mem_rdata, mem_ack,
      output rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// On a miss the core stalls while a dirty victim is written back word by
// word and the new line is filled. The held access then replays as a hit.
module dcache_wb #(
   parameter int INDEX_BITS = 3
) (
   input  logic       clk,
   input  logic       rst,
   dcache_wb_if.slave bus
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 28 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [LINES-1:0]  r_valid;
   logic [LINES-1:0]  r_dirty;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [31:0]       r_data [LINES][4];
   logic [1:0]        r_cnt;
   logic [27:0]       r_line;
   logic [31:0]       r_hit_cnt;
   logic [31:0]       r_miss_cnt;

   logic                  w_req;
   logic                  w_idle;
   logic [27:0]           w_sel_line;
   logic [INDEX_BITS-1:0] w_index;
   logic [TAG_W-1:0]      w_tag;
   logic [1:0]            w_off;
   logic                  w_hit;
   logic                  w_miss_start;
   logic                  w_store_hit;
   logic                  w_mem_req;
   logic                  w_mem_we;
   logic [31:0]           w_mem_addr;
   logic [31:0]           w_mem_wdata;
   logic                  w_fill_we;
   logic                  w_fill_done;
   logic                  w_to_fill;
   logic                  w_unused_addr;

   // While a miss is in flight the line comes from the latched address.
   // In IDLE it comes straight from the core.
   assign w_req         = bus.rd_req | bus.wr_req;
   assign w_idle        = (r_state == IDLE);
   assign w_sel_line    = w_idle ? bus.addr[31:4] : r_line;
   assign w_index       = w_sel_line[INDEX_BITS-1:0];
   assign w_tag         = w_sel_line[27:INDEX_BITS];
   assign w_off         = bus.addr[3:2];
   assign w_hit         = w_idle & w_req & r_valid[w_index] & (r_tag[w_index] == w_tag);
   assign w_miss_start  = w_idle & w_req & ~w_hit;
   assign w_store_hit   = w_hit & bus.wr_req;
   assign w_unused_addr = ^bus.addr[1:0];

   assign bus.rd_data   = r_data[w_index][w_off];
   assign bus.miss      = rst ? w_req : ((w_req & ~w_hit) | ~w_idle);
   assign bus.mem_req   = w_mem_req & ~rst;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;
   assign bus.hit_cnt   = r_hit_cnt;
   assign bus.miss_cnt  = r_miss_cnt;

   // Next-state logic and memory-side outputs for the miss sequencer.
   always_comb begin
      w_next      = r_state;
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_fill_we   = 1'b0;
      w_fill_done = 1'b0;
      w_to_fill   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_miss_start) begin
               if (r_valid[w_index] & r_dirty[w_index]) begin
                  w_next = WB;
               end else begin
                  w_next    = FILL;
                  w_to_fill = 1'b1;
               end
            end
         end
         WB: begin
            w_mem_req   = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = {r_tag[w_index], w_index, r_cnt, 2'b00};
            w_mem_wdata = r_data[w_index][r_cnt];
            if (bus.mem_ack && r_cnt == 2'd3) begin
               w_next    = FILL;
               w_to_fill = 1'b1;
            end
         end
         FILL: begin
            w_mem_req  = 1'b1;
            w_mem_addr = {r_line, r_cnt, 2'b00};
            if (bus.mem_ack) begin
               w_fill_we = 1'b1;
               if (r_cnt == 2'd3) begin
                  w_fill_done = 1'b1;
                  w_next      = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Control state: FSM, word counter, line status bits and perf counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= 2'd0;
         r_valid    <= '0;
         r_dirty    <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_miss_start) begin
            r_cnt      <= 2'd0;
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
         if (!w_idle && bus.mem_ack) r_cnt <= r_cnt + 2'd1;
         if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
         if (w_store_hit && (|bus.wr_be)) r_dirty[w_index] <= 1'b1;
         // The victim's words get overwritten during the fill, so the line is
         // invalid until the last word lands. An abandoned fill leaves it invalid.
         if (w_to_fill) begin
            r_valid[w_index] <= 1'b0;
            r_dirty[w_index] <= 1'b0;
         end
         if (w_fill_done) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
         end
      end
   end

   // Data path: line address latch, tag array and data array (no reset).
   always_ff @(posedge clk) begin
      if (w_miss_start) r_line <= bus.addr[31:4];
      if (w_store_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wr_be[b]) r_data[w_index][w_off][8*b +: 8] <= bus.wr_data[8*b +: 8];
         end
      end
      if (w_fill_we) r_data[w_index][r_cnt] <= bus.mem_rdata;
      if (w_fill_done) r_tag[w_index] <= r_line[27:INDEX_BITS];
   end
endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 3, giving the line index width (2^INDEX_BITS lines).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port addr  input  32  CPU byte address (MEM-stage AluOut).
REQ-005 SHALL have port rd_req  input  1  CPU load request.
REQ-006 SHALL have port wr_req  input  1  CPU store request.
REQ-007 SHALL have port wr_be  input  4  store byte enables.
REQ-008 SHALL have port wr_data  input  32  store data.
REQ-009 SHALL have port rd_data  output  32  load data, word at addr.
REQ-010 SHALL have port miss  output  1  stall request to hazard unit (drives DCacheMiss).
REQ-011 SHALL have port mem_req  output  1  memory word-transfer request.
REQ-012 SHALL have port mem_we  output  1  1 = write-back word, 0 = fill word.
REQ-013 SHALL have port mem_addr  output  32  word-aligned memory address.
REQ-014 SHALL have port mem_wdata  output  32  write-back word.
REQ-015 SHALL have port mem_rdata  input  32  fill word, valid when mem_ack=1.
REQ-016 SHALL have port mem_ack  input  1  completes the current word transfer.
REQ-017 SHALL have ports hit_cnt, miss_cnt  output  32 each  performance counters.

Function
REQ-018 SHALL be direct-mapped, write-back, write-allocate; 4 words/line; offset=addr[3:2], index=addr[3+INDEX_BITS:4], tag=addr[31:4+INDEX_BITS]; addr[1:0] ignored.
REQ-019 SHALL keep per line: valid, dirty, tag, 4x32 data.
REQ-020 SHALL treat req = rd_req|wr_req; rd_req and wr_req both high treated as store.
REQ-021 SHALL compute hit = state IDLE & req & valid[index] & tag match, combinationally.
REQ-022 SHALL drive miss = (req & !hit) | (state != IDLE), combinationally, same cycle as request.
REQ-023 SHALL drive rd_data combinationally from the addressed word whenever index/tag/offset select it; value undefined on miss.
REQ-024 SHALL on store hit write bytes with wr_be set at next edge; set dirty only if |wr_be.
REQ-025 SHALL implement FSM states IDLE, WB, FILL.
REQ-026 SHALL in IDLE on req & !hit: latch addr; go WB if victim valid&dirty, else FILL; clear word counter cnt (2 bits); increment miss_cnt.
REQ-027 SHALL in WB hold mem_req=1, mem_we=1, mem_addr={victim tag, index, cnt, 2'b00}, mem_wdata=victim word cnt; on mem_ack cnt++; on mem_ack with cnt=3 go FILL, cnt=0.
REQ-028 SHALL in FILL hold mem_req=1, mem_we=0, mem_addr={latched tag, index, cnt, 2'b00}; on mem_ack store mem_rdata into word cnt, cnt++; on mem_ack with cnt=3 set tag, valid=1, dirty=0, go IDLE.
REQ-029 SHALL keep mem_req=0 in IDLE; mem_addr/mem_wdata stable while mem_req=1 and mem_ack=0.
REQ-030 SHALL rely on the core holding addr/rd_req/wr_req/wr_be/wr_data stable while miss=1; the held access replays as a hit in the first IDLE cycle after FILL.
REQ-031 SHALL increment hit_cnt on every IDLE cycle with hit=1, replay included; counters wrap at 2^32.
REQ-032 SHALL ignore mem_ack in IDLE.

Reset
REQ-033 SHALL on rst clear all valid and dirty bits, state=IDLE, cnt=0, hit_cnt=0, miss_cnt=0; data/tag arrays not reset.
REQ-034 SHALL with rst high drive mem_req=0, miss=req (all lines invalid).
REQ-035 SHALL on rst mid-WB or mid-FILL abandon the transfer: mem_req=0 the following cycle, line left invalid.

Verification
REQ-036 Cold load addr=0x100 after reset, mem_ack every cycle -> miss=1 for 5 cycles, 4 fill reads at 0x100,0x104,0x108,0x10C, then hit, rd_data=word at 0x100, miss_cnt=1, hit_cnt=1.
REQ-037 Store 0xDEADBEEF be=4'b0011 to cached 0x104 then load 0x104 -> upper bytes unchanged, low half 0xBEEF, dirty=1, no mem_req.
REQ-038 Load 0x180 (same index as dirty 0x100, INDEX_BITS=3) -> 4 writes at 0x100..0x10C with stored data, then 4 reads 0x180..0x18C, miss_cnt+1.
REQ-039 Fill with mem_ack delayed 3 cycles per word -> mem_addr stable during wait, miss held 16+ cycles, correct data.
REQ-040 rst asserted during FILL word 2 -> mem_req=0 next cycle, counters 0, subsequent load same addr misses again.
